// File: rtl/snake_game_fsm.sv
// snake_game_fsm: game-state controller for the snake renderer.
// Holds a 16-entry body list (8-bit cell = row*16 + col on a 16x16 grid), the
// length, the direction and the food cell. It advances the snake on each Tick
// and reports win/loss through one-hot state flags.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Start                 begin a game (Qi) / return to idle (Ql, Qw)
//   Tick                  single-cycle move pulse, honoured only in Qp
//   BtnU/BtnD/BtnL/BtnR   direction requests, priority U > D > L > R
//   Locations_Flat        segment k at [127-8k -: 8]; segment 0 is the head
//   Length, Food          live segment count, food cell
//   Qi Qp Qm Qc Ql Qw     one-hot state flags
//
// Build option: define SNAKE_WRAP_EN to make wall crossings wrap around
// instead of losing the game.
module snake_game_fsm #(
  parameter int unsigned WIN_LEN   = 15,
  parameter logic [7:0]  INIT_HEAD = 8'h88,
  parameter logic [7:0]  FOOD_INIT = 8'h8C,
  parameter logic [7:0]  LFSR_SEED = 8'hB5
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Tick,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnL,
  input  logic         BtnR,
  output logic [127:0] Locations_Flat,
  output logic [3:0]   Length,
  output logic [7:0]   Food,
  output logic         Qi,
  output logic         Qp,
  output logic         Qm,
  output logic         Qc,
  output logic         Ql,
  output logic         Qw
);

  localparam logic [5:0] S_QI = 6'b000001;
  localparam logic [5:0] S_QP = 6'b000010;
  localparam logic [5:0] S_QM = 6'b000100;
  localparam logic [5:0] S_QC = 6'b001000;
  localparam logic [5:0] S_QL = 6'b010000;
  localparam logic [5:0] S_QW = 6'b100000;

  // Encoding chosen so that the reverse of a direction is dir ^ 1.
  localparam logic [1:0] DIR_U = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_R = 2'd3;

  logic [5:0]       state_q, state_d;
  logic [15:0][7:0] seg_q, seg_d;
  logic [3:0]       len_q, len_d;
  logic [7:0]       food_q, food_d;
  logic [1:0]       dir_q, dir_d;
  logic [7:0]       lfsr_q, lfsr_d;

  logic [3:0] row, col, nrow, ncol;
  logic [7:0] nh;
  logic       wall, wall_loss, self_hit, lfsr_hit, btn_any;
  logic [1:0] btn_dir;

  // Next-head computation; 4-bit coordinate arithmetic wraps by itself, so
  // the wrap build only has to suppress the loss.
  always_comb begin
    row  = seg_q[0][7:4];
    col  = seg_q[0][3:0];
    nrow = row;
    ncol = col;
    wall = 1'b0;
    case (dir_q)
      DIR_U:   begin nrow = row - 4'd1; wall = (row == 4'd0);  end
      DIR_D:   begin nrow = row + 4'd1; wall = (row == 4'd15); end
      DIR_L:   begin ncol = col - 4'd1; wall = (col == 4'd0);  end
      default: begin ncol = col + 4'd1; wall = (col == 4'd15); end
    endcase
    nh = {nrow, ncol};
`ifdef SNAKE_WRAP_EN
    wall_loss = 1'b0;
`else
    wall_loss = wall;
`endif
    // The tail slot (Length-1) is vacated by this move, so it cannot collide.
    self_hit = 1'b0;
    lfsr_hit = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      if ((k + 1) < 32'(len_q) && seg_q[k] == nh)     self_hit = 1'b1;
      if (k < 32'(len_q)       && seg_q[k] == lfsr_q) lfsr_hit = 1'b1;
    end
    btn_any = BtnU | BtnD | BtnL | BtnR;
    if (BtnU)      btn_dir = DIR_U;
    else if (BtnD) btn_dir = DIR_D;
    else if (BtnL) btn_dir = DIR_L;
    else           btn_dir = DIR_R;
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    len_d   = len_q;
    food_d  = food_q;
    dir_d   = dir_q;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      S_QI: if (Start) begin
        seg_d[0] = INIT_HEAD;
        seg_d[1] = INIT_HEAD - 8'd1;
        seg_d[2] = INIT_HEAD - 8'd2;
        len_d    = 4'd3;
        dir_d    = DIR_R;
        food_d   = FOOD_INIT;
        state_d  = S_QP;
      end
      S_QP: begin
        if (btn_any && btn_dir != (dir_q ^ 2'b01)) dir_d = btn_dir;
        if (Tick) state_d = S_QM;
      end
      S_QM: begin
        if (wall_loss || self_hit) begin
          state_d = S_QL;
        end else begin
          for (int unsigned k = 1; k < 16; k++) seg_d[k] = seg_q[k-1];
          seg_d[0] = nh;
          if (nh == food_q) begin
            len_d   = len_q + 4'd1;
            state_d = ((len_q + 4'd1) == 4'(WIN_LEN)) ? S_QW : S_QC;
          end else begin
            state_d = S_QP;
          end
        end
      end
      S_QC: if (!lfsr_hit) begin
        food_d  = lfsr_q;
        state_d = S_QP;
      end
      S_QL, S_QW: if (Start) begin
        len_d   = '0;
        state_d = S_QI;
      end
      default: state_d = S_QI;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_QI;
      seg_q   <= '0;
      len_q   <= '0;
      food_q  <= '0;
      dir_q   <= DIR_R;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      food_q  <= food_d;
      dir_q   <= dir_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_comb begin
    Locations_Flat = '0;
    for (int unsigned k = 0; k < 16; k++) Locations_Flat[127 - 8*k -: 8] = seg_q[k];
  end

  assign Length = len_q;
  assign Food   = food_q;
  assign Qi     = state_q[0];
  assign Qp     = state_q[1];
  assign Qm     = state_q[2];
  assign Qc     = state_q[3];
  assign Ql     = state_q[4];
  assign Qw     = state_q[5];

endmodule
